// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/writeback stage: opcodes, FSM states, default width.
package alu_pkg;

  localparam int unsigned DATA_W_DEFAULT = 8;
  localparam int unsigned OP_W           = 3;

  localparam logic [OP_W-1:0] OP_ADD  = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB  = 3'b001;
  localparam logic [OP_W-1:0] OP_AND  = 3'b010;
  localparam logic [OP_W-1:0] OP_XOR  = 3'b011;
  localparam logic [OP_W-1:0] OP_OR   = 3'b100;
  localparam logic [OP_W-1:0] OP_NAND = 3'b101;
  localparam logic [OP_W-1:0] OP_NOR  = 3'b110;
  localparam logic [OP_W-1:0] OP_XNOR = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_regfile.sv
// Architectural register file: two combinational read ports, one synchronous write port,
// asynchronously cleared on rst.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned NREGS  = 4,
  parameter int unsigned REG_AW = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] raddr1,
  input  logic [REG_AW-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];

  always_comb begin
    regs_d = regs_q;
    if (we) begin
      regs_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rdata1 = regs_q[raddr1];
  assign rdata2 = regs_q[raddr2];

endmodule

// File: rtl/alu_issue_stage.sv
// Non-pipelined issue/writeback stage wrapping an external combinational ALU.
// Optional result flags (res_zero/res_neg) are enabled with `define ALU_FLAGS_EN.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned NREGS  = 4,
  parameter int unsigned REG_AW = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_load,
  input  logic [OP_W-1:0]   in_op,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic [DATA_W-1:0] in_imm,
  output logic [OP_W-1:0]   alu_opcode,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_y,
`ifdef ALU_FLAGS_EN
  output logic              res_zero,
  output logic              res_neg,
`endif
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [REG_AW-1:0] res_rd
);

  state_e            state_q, state_d;
  logic              load_q, load_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [OP_W-1:0]   opcode_q, opcode_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic              res_valid_q, res_valid_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic [REG_AW-1:0] res_rd_q, res_rd_d;
`ifdef ALU_FLAGS_EN
  logic              zero_q, zero_d;
  logic              neg_q, neg_d;
`endif

  logic [DATA_W-1:0] rf_rdata1, rf_rdata2;
  logic              rf_we;
  logic [DATA_W-1:0] wb_value_c;

  alu_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .REG_AW (REG_AW)
  ) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .raddr1 (in_rs1),
    .raddr2 (in_rs2),
    .rdata1 (rf_rdata1),
    .rdata2 (rf_rdata2),
    .we     (rf_we),
    .waddr  (rd_q),
    .wdata  (wb_value_c)
  );

  // Loads bypass the ALU; the write-back value is ready during EXEC.
  assign wb_value_c = load_q ? imm_q : alu_y;

  always_comb begin
    state_d     = state_q;
    load_d      = load_q;
    rd_d        = rd_q;
    imm_d       = imm_q;
    opcode_d    = opcode_q;
    a_d         = a_q;
    b_d         = b_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_rd_d    = res_rd_q;
`ifdef ALU_FLAGS_EN
    zero_d      = zero_q;
    neg_d       = neg_q;
`endif
    rf_we       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          load_d  = in_load;
          rd_d    = in_rd;
          imm_d   = in_imm;
          if (!in_load) begin
            opcode_d = in_op;
            a_d      = rf_rdata1;
            b_d      = rf_rdata2;
          end
          state_d = EXEC;
        end
      end
      EXEC: begin
        rf_we       = 1'b1;
        res_data_d  = wb_value_c;
        res_rd_d    = rd_q;
        res_valid_d = 1'b1;
`ifdef ALU_FLAGS_EN
        zero_d      = (wb_value_c == '0);
        neg_d       = wb_value_c[DATA_W-1];
`endif
        state_d     = DONE;
      end
      DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      load_q      <= 1'b0;
      rd_q        <= '0;
      imm_q       <= '0;
      opcode_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_rd_q    <= '0;
`ifdef ALU_FLAGS_EN
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      load_q      <= load_d;
      rd_q        <= rd_d;
      imm_q       <= imm_d;
      opcode_q    <= opcode_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_rd_q    <= res_rd_d;
`ifdef ALU_FLAGS_EN
      zero_q      <= zero_d;
      neg_q       <= neg_d;
`endif
    end
  end

  // in_ready depends on state only, never on in_valid or res_ready.
  assign in_ready   = (state_q == IDLE);
  assign alu_opcode = opcode_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_rd     = res_rd_q;
`ifdef ALU_FLAGS_EN
  assign res_zero   = zero_q;
  assign res_neg    = neg_q;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage with a behavioural ALU driving alu_y.
module tb_alu_issue_stage;
  import alu_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 2;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [AW-1:0] rd;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_load;
  logic [2:0]    in_op;
  logic [AW-1:0] in_rd, in_rs1, in_rs2;
  logic [DW-1:0] in_imm;
  logic [2:0]    alu_opcode;
  logic [DW-1:0] alu_a, alu_b, alu_y;
  logic          res_valid, res_ready;
  logic [DW-1:0] res_data;
  logic [AW-1:0] res_rd;
`ifdef ALU_FLAGS_EN
  logic          res_zero, res_neg;
`endif

  int n_checks = 0;
  int n_errors = 0;
  exp_t sb_q[$];
  logic [DW-1:0] rf_model [4];

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_load    (in_load),
    .in_op      (in_op),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_imm     (in_imm),
    .alu_opcode (alu_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_y      (alu_y),
`ifdef ALU_FLAGS_EN
    .res_zero   (res_zero),
    .res_neg    (res_neg),
`endif
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_rd     (res_rd)
  );

  function automatic logic [DW-1:0] alu_fn(input logic [2:0] op, input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_XOR:  return a ^ b;
      OP_OR:   return a | b;
      OP_NAND: return ~(a & b);
      OP_NOR:  return ~(a | b);
      default: return ~(a ^ b);
    endcase
  endfunction

  always_comb alu_y = alu_fn(alu_opcode, alu_a, alu_b);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Issue one instruction, check the ALU drive, wait for the result, hold it
  // for hold_cycles with res_ready low, then retire it.
  task automatic run_instr(input logic ld, input logic [2:0] op, input logic [AW-1:0] rd,
                           input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                           input logic [DW-1:0] imm, input int hold_cycles);
    exp_t e;
    exp_t got;
    int n;
    logic [DW-1:0] a_exp, b_exp;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_idle", 32'(in_ready), 32'd1);
    a_exp   = rf_model[rs1];
    b_exp   = rf_model[rs2];
    e.data  = ld ? imm : alu_fn(op, a_exp, b_exp);
    e.rd    = rd;
    rf_model[rd] = e.data;
    sb_q.push_back(e);
    in_valid = 1'b1; in_load = ld; in_op = op; in_rd = rd;
    in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    res_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("in_ready_exec", 32'(in_ready), 32'd0);
    check("res_valid_exec", 32'(res_valid), 32'd0);
    if (!ld) begin
      check("alu_opcode", 32'(alu_opcode), 32'(op));
      check("alu_a", 32'(alu_a), 32'(a_exp));
      check("alu_b", 32'(alu_b), 32'(b_exp));
    end
    @(negedge clk);
    check("res_valid_latency", 32'(res_valid), 32'd1);
    n = 0;
    while (!res_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!res_valid) begin
      check("res_valid_timeout", 32'(res_valid), 32'd1);
      void'(sb_q.pop_front());
    end else begin
      e = sb_q.pop_front();
      got.data = res_data;
      got.rd   = res_rd;
      check("res_data", 32'(res_data), 32'(e.data));
      check("res_rd", 32'(res_rd), 32'(e.rd));
`ifdef ALU_FLAGS_EN
      check("res_zero", 32'(res_zero), 32'(e.data == '0));
      check("res_neg", 32'(res_neg), 32'(e.data[DW-1]));
`endif
      for (int i = 0; i < hold_cycles; i++) begin
        @(negedge clk);
        check("hold_valid", 32'(res_valid), 32'd1);
        check("hold_data", 32'(res_data), 32'(got.data));
        check("hold_rd", 32'(res_rd), 32'(got.rd));
        check("hold_in_ready", 32'(in_ready), 32'd0);
      end
      res_ready = 1'b1;
      @(negedge clk);
      check("retire_valid", 32'(res_valid), 32'd0);
      check("retire_in_ready", 32'(in_ready), 32'd1);
      res_ready = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_load = 1'b0; in_op = '0;
    in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0; res_ready = 1'b0;
    for (int i = 0; i < 4; i++) rf_model[i] = '0;
    repeat (2) @(negedge clk);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data", 32'(res_data), 32'd0);
    check("rst_res_rd", 32'(res_rd), 32'd0);
    check("rst_alu_opcode", 32'(alu_opcode), 32'd0);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_alu_b", 32'(alu_b), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Idle with in_valid low must not advance.
    repeat (3) @(negedge clk);
    check("idle_stays", 32'(in_ready), 32'd1);
    check("idle_no_result", 32'(res_valid), 32'd0);

    run_instr(1'b1, OP_ADD,  2'd1, 2'd0, 2'd0, 8'h0F, 0);
    run_instr(1'b1, OP_ADD,  2'd2, 2'd0, 2'd0, 8'h03, 0);
    run_instr(1'b0, OP_ADD,  2'd3, 2'd1, 2'd2, 8'h00, 0);
    run_instr(1'b0, OP_SUB,  2'd0, 2'd2, 2'd1, 8'h00, 0);
    run_instr(1'b0, OP_XOR,  2'd3, 2'd0, 2'd1, 8'h00, 0);
    check("raw_xor_value", 32'(rf_model[3]), 32'h0000_00FB);
    run_instr(1'b0, OP_NAND, 2'd0, 2'd1, 2'd2, 8'h00, 5);
    run_instr(1'b0, OP_XOR,  2'd3, 2'd1, 2'd1, 8'h00, 0);
    run_instr(1'b0, OP_SUB,  2'd3, 2'd2, 2'd1, 8'h00, 1);

    for (int k = 0; k < 10; k++) begin
      run_instr(1'($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
                2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
                int'($urandom_range(0, 2)));
    end

    // Reset during EXEC of an ADD: instruction discarded, file cleared.
    @(negedge clk);
    in_valid = 1'b1; in_load = 1'b0; in_op = OP_ADD; in_rd = 2'd3;
    in_rs1 = 2'd1; in_rs2 = 2'd2;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_exec", 32'(in_ready), 32'd0);
    rst = 1'b1;
    #1;
    check("async_rst_in_ready", 32'(in_ready), 32'd1);
    check("async_rst_alu_a", 32'(alu_a), 32'd0);
    check("async_rst_alu_b", 32'(alu_b), 32'd0);
    check("async_rst_opcode", 32'(alu_opcode), 32'd0);
    check("async_rst_res_data", 32'(res_data), 32'd0);
    check("async_rst_res_valid", 32'(res_valid), 32'd0);
    for (int i = 0; i < 4; i++) rf_model[i] = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("no_result_after_rst", 32'(res_valid), 32'd0);
    end
    run_instr(1'b0, OP_ADD, 2'd3, 2'd1, 2'd2, 8'h00, 0);
    check("post_rst_add", 32'(rf_model[3]), 32'd0);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
